// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants (active-low, bit order g..a) and capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG7_0    = 7'b1000000;
  localparam logic [6:0] SEG7_1    = 7'b1111001;
  localparam logic [6:0] SEG7_2    = 7'b0100100;
  localparam logic [6:0] SEG7_3    = 7'b0110000;
  localparam logic [6:0] SEG7_4    = 7'b0011001;
  localparam logic [6:0] SEG7_5    = 7'b0010010;
  localparam logic [6:0] SEG7_6    = 7'b0000010;
  localparam logic [6:0] SEG7_7    = 7'b1111000;
  localparam logic [6:0] SEG7_8    = 7'b0000000;
  localparam logic [6:0] SEG7_9    = 7'b0010000;
  localparam logic [6:0] SEG7_A    = 7'b0001000;
  localparam logic [6:0] SEG7_B    = 7'b0000011;
  localparam logic [6:0] SEG7_C    = 7'b1000110;
  localparam logic [6:0] SEG7_D    = 7'b0100001;
  localparam logic [6:0] SEG7_E    = 7'b0000110;
  localparam logic [6:0] SEG7_F    = 7'b0001110;
  localparam logic [6:0] SEG7_DASH = 7'b0111111;

  typedef enum logic {
    ST_SYNC    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display bus as seen by the capture block: scanner pins in, decoded frame out.
// err_count exists only when SEG7_CAPTURE_ERRCNT_EN is defined.
interface seg7_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   ovf;
  logic [NUM_DIGITS-1:0]   bad;
  logic                    frame_valid;
`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0]              err_count;
`endif

  modport master (
    output seg, an,
`ifdef SEG7_CAPTURE_ERRCNT_EN
    input  err_count,
`endif
    input  value, ovf, bad, frame_valid
  );

  modport slave (
    input  seg, an,
`ifdef SEG7_CAPTURE_ERRCNT_EN
    output err_count,
`endif
    output value, ovf, bad, frame_valid
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern -> hex nibble, with dash (ovf) and undecodable (bad) flags.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       ovf,
  output logic       bad
);

  always_comb begin
    nibble = 4'h0;
    ovf    = 1'b0;
    bad    = 1'b0;
    case (seg)
      SEG7_0:    nibble = 4'h0;
      SEG7_1:    nibble = 4'h1;
      SEG7_2:    nibble = 4'h2;
      SEG7_3:    nibble = 4'h3;
      SEG7_4:    nibble = 4'h4;
      SEG7_5:    nibble = 4'h5;
      SEG7_6:    nibble = 4'h6;
      SEG7_7:    nibble = 4'h7;
      SEG7_8:    nibble = 4'h8;
      SEG7_9:    nibble = 4'h9;
      SEG7_A:    nibble = 4'hA;
      SEG7_B:    nibble = 4'hB;
      SEG7_C:    nibble = 4'hC;
      SEG7_D:    nibble = 4'hD;
      SEG7_E:    nibble = 4'hE;
      SEG7_F:    nibble = 4'hF;
      SEG7_DASH: ovf    = 1'b1;
      default:   bad    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples the multiplexed display bus, debounces each digit and publishes whole frames.
// Optional saturating bad-pattern counter enabled by SEG7_CAPTURE_ERRCNT_EN.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                reset,
  seg7_scan_capture_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SMP_W = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_PRE    = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [NUM_DIGITS-1:0] MASK_FIRST = NUM_DIGITS'(1);

  logic [6:0]              s_seg_q;
  logic [NUM_DIGITS-1:0]   s_an_q;
  logic [SMP_W-1:0]        smp, prev_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    same, onehot, accept;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              dec_nib;
  logic                    dec_ovf, dec_bad;
  state_t                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, value_q, value_d;
  logic [NUM_DIGITS-1:0]   sh_ovf_q, sh_ovf_d, sh_bad_q, sh_bad_d;
  logic [NUM_DIGITS-1:0]   ovf_q, ovf_d, bad_q, bad_d;
  logic                    frame_valid_q, frame_valid_d;

  seg7_pattern_decode u_decode (
    .seg    (s_seg_q),
    .nibble (dec_nib),
    .ovf    (dec_ovf),
    .bad    (dec_bad)
  );

  // Stability counter: an accept fires once, on the cycle the count reaches its ceiling.
  assign onehot = ($countones(~s_an_q) == 1);

  always_comb begin
    smp    = {s_an_q, s_seg_q};
    same   = (smp == prev_q);
    cnt_d  = '0;
    if (same) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    accept = same && (cnt_q == CNT_PRE) && onehot;
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an_q[i]) idx = IDX_W'(i);
    end
  end

  // Frame assembly: digit 0 opens (or reopens) a frame; a full mask publishes next cycle.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    sh_val_d      = sh_val_q;
    sh_ovf_d      = sh_ovf_q;
    sh_bad_d      = sh_bad_q;
    value_d       = value_q;
    ovf_d         = ovf_q;
    bad_d         = bad_q;
    frame_valid_d = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (accept && idx == '0) begin
          sh_val_d[3:0] = dec_nib;
          sh_ovf_d[0]   = dec_ovf;
          sh_bad_d[0]   = dec_bad;
          mask_d        = MASK_FIRST;
          state_d       = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (&mask_q) begin
          value_d       = sh_val_q;
          ovf_d         = sh_ovf_q;
          bad_d         = sh_bad_q;
          frame_valid_d = 1'b1;
          mask_d        = '0;
          state_d       = ST_SYNC;
        end else if (accept) begin
          sh_val_d[4*idx +: 4] = dec_nib;
          sh_ovf_d[idx]        = dec_ovf;
          sh_bad_d[idx]        = dec_bad;
          if (idx == '0) mask_d = MASK_FIRST;
          else           mask_d[idx] = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg_q       <= '1;
      s_an_q        <= '1;
      prev_q        <= '1;
      cnt_q         <= '0;
      state_q       <= ST_SYNC;
      mask_q        <= '0;
      sh_val_q      <= '0;
      sh_ovf_q      <= '0;
      sh_bad_q      <= '0;
      value_q       <= '0;
      ovf_q         <= '0;
      bad_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      s_seg_q       <= bus.seg;
      s_an_q        <= bus.an;
      prev_q        <= smp;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      mask_q        <= mask_d;
      sh_val_q      <= sh_val_d;
      sh_ovf_q      <= sh_ovf_d;
      sh_bad_q      <= sh_bad_d;
      value_q       <= value_d;
      ovf_q         <= ovf_d;
      bad_q         <= bad_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.ovf         = ovf_q;
  assign bus.bad         = bad_q;
  assign bus.frame_valid = frame_valid_q;

`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (accept && dec_bad && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomized bench for seg7_scan_capture with a run-length/array reference model and directed scans.
module tb_seg7_scan_capture;

  localparam int ND     = 4;
  localparam int STABLE = 4;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] PAT [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   fv_cnt = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a digit is taken when its {an,seg} pin value has been seen for exactly
  // STABLE consecutive samples, judged one clock later (the input register).
  logic [10:0] m_last;
  int          m_run;
  bit          m_inframe, m_pend;
  bit   [3:0]  m_seen;
  logic [3:0]  m_nib [ND];
  logic        m_o [ND];
  logic        m_b [ND];
  logic [15:0] m_value;
  logic [3:0]  m_ovf, m_bad;
  logic        m_fv;
  int          m_err;

  function automatic void mdec(input logic [6:0] p, output logic [3:0] n, output logic o,
                               output logic b);
    n = 4'h0; o = 1'b0; b = 1'b1;
    for (int i = 0; i < 16; i++) if (p == PAT[i]) begin n = i[3:0]; b = 1'b0; end
    if (p == DASH) begin o = 1'b1; b = 1'b0; end
  endfunction

  always @(posedge clk) begin
    logic [3:0] n;
    logic o, b;
    int d;
    bit acc;
    if (reset) begin
      m_last = '1; m_run = 2; m_inframe = 0; m_pend = 0; m_seen = 0;
      for (int i = 0; i < ND; i++) begin m_nib[i] = 0; m_o[i] = 0; m_b[i] = 0; end
      m_value = 0; m_ovf = 0; m_bad = 0; m_fv = 0; m_err = 0;
    end else begin
      m_fv = 1'b0;
      acc = (m_run == STABLE) && ($countones(~m_last[10:7]) == 1);
      d = 0;
      for (int i = 0; i < ND; i++) if (!m_last[7+i]) d = i;
      mdec(m_last[6:0], n, o, b);
      if (acc && b && m_err < 255) m_err++;
      if (m_pend) begin
        for (int i = 0; i < ND; i++) begin
          m_value[4*i +: 4] = m_nib[i]; m_ovf[i] = m_o[i]; m_bad[i] = m_b[i];
        end
        m_fv = 1'b1; m_pend = 0; m_inframe = 0; m_seen = 0;
      end else if (acc && (m_inframe || d == 0)) begin
        if (d == 0) m_seen = 4'b0001;
        else        m_seen[d] = 1'b1;
        m_inframe = 1;
        m_nib[d] = n; m_o[d] = o; m_b[d] = b;
        if (m_seen == 4'hF) m_pend = 1;
      end
      if ({bus.an, bus.seg} == m_last) begin
        if (m_run <= STABLE) m_run++;
      end else begin
        m_last = {bus.an, bus.seg};
        m_run  = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.frame_valid === 1'b1) fv_cnt++;
      check("outputs{value,ovf,bad,fv}", {39'd0, bus.value, bus.ovf, bus.bad, bus.frame_valid},
            {39'd0, m_value, m_ovf, m_bad, m_fv});
`ifdef SEG7_CAPTURE_ERRCNT_EN
      check("err_count", {56'd0, bus.err_count}, {56'd0, m_err[7:0]});
`endif
    end
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an  = a;
    bus.seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    hold(~(4'b0001 << d), s, n);
  endtask

  task automatic blank(input int n);
    hold(4'hF, BLANK, n);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int fv0, seq, dg, hl, r;
    logic [3:0] a;
    logic [6:0] s;
    reset   = 1'b1;
    bus.an  = 4'hF;
    bus.seg = BLANK;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset_value", {48'd0, bus.value}, 64'h0);
    check("reset_ovf", {60'd0, bus.ovf}, 64'h0);
    check("reset_bad", {60'd0, bus.bad}, 64'h0);
    check("reset_fv", {63'd0, bus.frame_valid}, 64'h0);

    // Plain scan 1,2,3,4
    fv0 = fv_cnt;
    for (int i = 0; i < 4; i++) show(i, PAT[i+1], 8);
    blank(6);
    check("scan_fv_count", 64'(fv_cnt - fv0), 64'd1);
    check("scan_value", {48'd0, bus.value}, 64'h4321);
    check("scan_ovf", {60'd0, bus.ovf}, 64'h0);
    check("scan_bad", {60'd0, bus.bad}, 64'h0);

    // Dash on digit 2
    for (int i = 0; i < 4; i++) show(i, (i == 2) ? DASH : PAT[0], 8);
    blank(6);
    check("dash_value", {48'd0, bus.value}, 64'h0);
    check("dash_ovf", {60'd0, bus.ovf}, 64'h4);
    check("dash_bad", {60'd0, bus.bad}, 64'h0);

    // Digit 1 too short, then a clean scan
    fv0 = fv_cnt;
    show(0, PAT[9], 8); show(1, PAT[10], 2); show(2, PAT[11], 8); show(3, PAT[12], 8);
    blank(6);
    check("short_fv_count", 64'(fv_cnt - fv0), 64'd0);
    for (int i = 0; i < 4; i++) show(i, PAT[i+5], 8);
    blank(6);
    check("short_next_value", {48'd0, bus.value}, 64'h8765);

    // Scan entering mid-frame at digit 2
    fv0 = fv_cnt;
    for (int k = 0; k < 6; k++) begin
      dg = (k + 2) % 4;
      show(dg, PAT[(dg == 0) ? 14 : (dg == 1) ? 15 : (dg == 2) ? 13 : 12], 8);
    end
    blank(6);
    check("late_fv_count", 64'(fv_cnt - fv0), 64'd1);
    check("late_value", {48'd0, bus.value}, 64'hCDFE);

    // Blank segments on digit 3
    for (int i = 0; i < 4; i++) show(i, (i == 3) ? BLANK : PAT[1], 8);
    blank(6);
    check("blankseg_bad", {60'd0, bus.bad}, 64'h8);
    check("blankseg_nib3", {60'd0, bus.value[15:12]}, 64'h0);
    check("blankseg_value", {48'd0, bus.value}, 64'h0111);
`ifdef SEG7_CAPTURE_ERRCNT_EN
    check("blankseg_err", {56'd0, bus.err_count}, 64'd1);
`endif

    // Reset after three captured digits
    fv0 = fv_cnt;
    for (int i = 0; i < 3; i++) show(i, PAT[i+2], 8);
    bus.an = 4'hF; bus.seg = BLANK;
    pulse_reset();
    blank(4);
    check("midreset_fv_count", 64'(fv_cnt - fv0), 64'd0);
    check("midreset_outputs", {40'd0, bus.value, bus.ovf, bus.bad}, 64'h0);
    for (int i = 0; i < 4; i++) show(i, PAT[9-i], 8);
    blank(6);
    check("midreset_next_value", {48'd0, bus.value}, 64'h6789);

    // Randomized scanning
    seq = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 85) begin seq = (seq + 1) % 4; dg = seq; end
      else dg = $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      if (r < 80)      s = PAT[$urandom_range(0, 15)];
      else if (r < 88) s = DASH;
      else             s = 7'($urandom);
      r = $urandom_range(0, 99);
      if (r < 90)      a = ~(4'b0001 << dg);
      else if (r < 95) a = 4'hF;
      else             a = 4'($urandom);
      hl = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(4, 9));
      hold(a, s, hl);
      if ($urandom_range(0, 99) < 2) pulse_reset();
    end
    blank(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
